// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared constants, tag-entry layout, controller state encoding
//               and address-field extraction helpers for the icache tag path.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int c_ADDR_W   = 32;
    localparam int c_INDEX_W  = 8;
    localparam int c_OFFSET_W = 4;
    localparam int c_TAG_W    = c_ADDR_W - c_INDEX_W - c_OFFSET_W;
    localparam int c_CNT_W    = 16;

    // One tag RAM word: valid bit on top of the stored address tag.
    typedef struct packed {
        logic               valid;
        logic [c_TAG_W-1:0] tag;
    } tag_entry_t;

    // Controller states; INIT and FLUSH both run the clearing sweep.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [c_INDEX_W-1:0] get_index(input logic [c_ADDR_W-1:0] addr);
        return addr[c_OFFSET_W +: c_INDEX_W];
    endfunction

    function automatic logic [c_TAG_W-1:0] get_tag(input logic [c_ADDR_W-1:0] addr);
        return addr[c_ADDR_W-1 -: c_TAG_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_tag_ctrl
// Description : Drives the icache tag SDP RAM: clears every set after reset
//               and on flush, installs refill tags and turns lookups into
//               hit/miss responses one cycle later, with hit/miss statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_tag_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int INDEX_W  = c_INDEX_W,
    parameter int OFFSET_W = c_OFFSET_W,
    parameter int CNT_W    = c_CNT_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_req,
    output logic                                flush_busy,
    input  logic                                lk_valid,
    output logic                                lk_ready,
    input  logic [ADDR_W-1:0]                   lk_addr,
    output logic                                rsp_valid,
    output logic                                rsp_hit,
    output logic [INDEX_W-1:0]                  rsp_index,
    input  logic                                refill_valid,
    output logic                                refill_ready,
    input  logic [ADDR_W-1:0]                   refill_addr,
    output logic                                tag_wr_en,
    output logic [INDEX_W-1:0]                  tag_wr_addr,
    output logic [ADDR_W-INDEX_W-OFFSET_W:0]    tag_wr_data,
    output logic [INDEX_W-1:0]                  tag_rd_addr,
    input  logic [ADDR_W-INDEX_W-OFFSET_W:0]    tag_rd_data,
    output logic [CNT_W-1:0]                    hit_cnt,
    output logic [CNT_W-1:0]                    miss_cnt
);

    localparam int c_ENTRY_TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [INDEX_W-1:0]       r_sweep_cnt;
    logic [INDEX_W-1:0]       r_rd_hold;
    logic [c_ENTRY_TAG_W-1:0] r_lk_tag;
    logic                     r_rsp_valid;
    logic [CNT_W-1:0]         r_hit_cnt;
    logic [CNT_W-1:0]         r_miss_cnt;

    logic                     w_sweep;
    logic                     w_sweep_last;
    logic                     w_idle;
    logic                     w_flush_go;
    logic                     w_refill_acc;
    logic                     w_lk_acc;
    logic                     w_hit;
    logic [INDEX_W-1:0]       w_lk_index;
    logic [INDEX_W-1:0]       w_rf_index;
    logic [c_ENTRY_TAG_W-1:0] w_lk_tag;
    logic [c_ENTRY_TAG_W-1:0] w_rf_tag;
    logic                     w_unused;

    assign w_lk_index = lk_addr[OFFSET_W +: INDEX_W];
    assign w_lk_tag   = lk_addr[ADDR_W-1 -: c_ENTRY_TAG_W];
    assign w_rf_index = refill_addr[OFFSET_W +: INDEX_W];
    assign w_rf_tag   = refill_addr[ADDR_W-1 -: c_ENTRY_TAG_W];

    // Line-offset bits carry no meaning for the tag array.
    assign w_unused = &{1'b0, lk_addr[OFFSET_W-1:0], refill_addr[OFFSET_W-1:0]};

    assign w_sweep      = (r_state == ST_INIT) || (r_state == ST_FLUSH);
    assign w_sweep_last = w_sweep && (r_sweep_cnt == '1);
    assign w_idle       = (r_state == ST_IDLE);
    assign w_flush_go   = w_idle && flush_req;

    // Flush outranks refill, refill outranks lookup, so RAM read and write
    // never happen in the same cycle.
    assign refill_ready = w_idle && !flush_req;
    assign lk_ready     = refill_ready && !refill_valid;
    assign w_refill_acc = refill_valid && refill_ready;
    assign w_lk_acc     = lk_valid && lk_ready;

    assign flush_busy   = w_sweep;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: sweep runs to the last index, flush only from IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  if (w_sweep_last) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (flush_req)    w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_sweep_last) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_INIT;
        endcase
    end

    // Sweep index: walks every set once, wrapping back to 0 at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep_cnt <= '0;
        end else if (w_flush_go) begin
            r_sweep_cnt <= '0;
        end else if (w_sweep) begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
        end
    end

    // RAM write port: sweep clears, otherwise install accepted refill tags.
    // The sweep enable is qualified by rst_n so nothing writes while held in reset.
    always_comb begin
        tag_wr_en   = 1'b0;
        tag_wr_addr = r_sweep_cnt;
        tag_wr_data = '0;
        if (w_sweep) begin
            tag_wr_en = rst_n;
        end else if (w_refill_acc) begin
            tag_wr_en   = 1'b1;
            tag_wr_addr = w_rf_index;
            tag_wr_data = {1'b1, w_rf_tag};
        end
    end

    // Read address follows the accepted lookup, otherwise holds the last index
    assign tag_rd_addr = w_lk_acc ? w_lk_index : r_rd_hold;

    // Lookup pipeline: capture index and tag to compare against next-cycle RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rd_hold   <= '0;
            r_lk_tag    <= '0;
        end else begin
            r_rsp_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_rd_hold <= w_lk_index;
                r_lk_tag  <= w_lk_tag;
            end
        end
    end

    assign w_hit     = r_rsp_valid && tag_rd_data[c_ENTRY_TAG_W] &&
                       (tag_rd_data[c_ENTRY_TAG_W-1:0] == r_lk_tag);
    assign rsp_valid = r_rsp_valid;
    assign rsp_hit   = w_hit;
    assign rsp_index = r_rd_hold;

    // Saturating statistics; flush entry wins over a coincident response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_flush_go) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_rsp_valid) begin
            if (w_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire
